// File: rtl/rupt_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rupt_controller_pkg : shared types and constants for RUPT handling    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rupt_controller_pkg;

    localparam int          NUM_RUPT     = 10;
    localparam int          DRAIN_CYCLES = 2;
    localparam logic [11:0] RUPT_BASE    = 12'o4004;
    localparam int          RUPT_STRIDE  = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        VECTOR,
        IN_RUPT
    } rupt_state_t;

    typedef enum logic [3:0] {
        T6, T5, T3, T4, KEY1, KEY2, UP, DOWN, RADAR, HAND
    } rupt_id_t;

    // 12-bit vector address of a source; legal parameters never wrap
    function automatic logic [11:0] rupt_vector(input logic [11:0] base,
                                                input int          stride,
                                                input logic [3:0]  id);
        return base + 12'(stride) * {8'd0, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rupt_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rupt_priority_encoder : lowest set index wins (index 0 = T6RUPT)      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rupt_priority_encoder
    import rupt_controller_pkg::*;
#(
    parameter int WIDTH = NUM_RUPT
) (
    input  logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic [3:0]       idx
);

    always_comb begin
        valid = |vec;
        idx   = 4'd0;
        // Scan downward so the lowest set index is the last assignment
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rupt_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rupt_controller : latches RUPT requests and sequences interrupt entry |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rupt_controller #(
    parameter int          NUM_RUPT     = rupt_controller_pkg::NUM_RUPT,
    parameter int          DRAIN_CYCLES = rupt_controller_pkg::DRAIN_CYCLES,
    parameter logic [11:0] RUPT_BASE    = rupt_controller_pkg::RUPT_BASE,
    parameter int          RUPT_STRIDE  = rupt_controller_pkg::RUPT_STRIDE
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_RUPT-1:0] rupt_req,
    input  logic                inhint_E,
    input  logic                relint_E,
    input  logic                resume_E,
    input  logic                ovf_A,
    input  logic                branch_E,
    input  logic                stall_D,
    input  logic [11:0]         pc_D,
    output logic                rupt_stall,
    output logic                rupt_flush,
    output logic                zrupt_we,
    output logic [11:0]         zrupt_data,
    output logic                redirect_en,
    output logic [11:0]         redirect_pc,
    output logic                in_rupt,
    output logic                inhibit,
    output logic [NUM_RUPT-1:0] pending,
    output logic [3:0]          active_id
);

    import rupt_controller_pkg::*;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    rupt_state_t         state;
    logic [CNT_W-1:0]    drain_cnt;
    logic [11:0]         ret_pc;
    logic [NUM_RUPT-1:0] req_prev;
    logic [NUM_RUPT-1:0] req_rise;
    logic [NUM_RUPT-1:0] clr_mask;
    logic                enc_valid;
    logic [3:0]          enc_idx;
    logic                take;

    rupt_priority_encoder #(
        .WIDTH (NUM_RUPT)
    ) u_prio (
        .vec   (pending),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    assign req_rise = rupt_req & ~req_prev;
    assign clr_mask = (state == VECTOR) ? (NUM_RUPT'(1) << active_id) : '0;
    assign take     = enc_valid & ~inhibit & ~ovf_A & ~branch_E & ~stall_D;

    assign zrupt_data  = ret_pc;
    assign redirect_pc = rupt_vector(RUPT_BASE, RUPT_STRIDE, active_id);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            ret_pc      <= 12'd0;
            req_prev    <= '0;
            pending     <= '0;
            inhibit     <= 1'b1;
            active_id   <= 4'd0;
            rupt_stall  <= 1'b0;
            rupt_flush  <= 1'b0;
            zrupt_we    <= 1'b0;
            redirect_en <= 1'b0;
            in_rupt     <= 1'b0;
        end else begin
            req_prev <= rupt_req;
            // A new edge on the bit being retired keeps it pending
            pending  <= (pending & ~clr_mask) | req_rise;

            if (inhint_E) begin
                inhibit <= 1'b1;
            end else if (relint_E) begin
                inhibit <= 1'b0;
            end

            rupt_stall  <= 1'b0;
            rupt_flush  <= 1'b0;
            zrupt_we    <= 1'b0;
            redirect_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= DRAIN;
                        ret_pc     <= pc_D;
                        active_id  <= enc_idx;
                        drain_cnt  <= '0;
                        rupt_stall <= 1'b1;
                        rupt_flush <= 1'b1;
                    end
                end
                DRAIN: begin
                    rupt_stall <= 1'b1;
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state     <= SAVE;
                        drain_cnt <= '0;
                        zrupt_we  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                SAVE: begin
                    state       <= VECTOR;
                    redirect_en <= 1'b1;
                end
                VECTOR: begin
                    state   <= IN_RUPT;
                    in_rupt <= 1'b1;
                end
                IN_RUPT: begin
                    if (resume_E) begin
                        state   <= IDLE;
                        in_rupt <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rupt_controller.md
# rupt_controller

Interrupt (RUPT) controller for the three-stage AGC core. Latches ten interrupt request sources and picks the highest-priority pending one when the core can accept it. It then sequences entry by freezing fetch, squashing decode, draining execute and writeback, saving the return address to ZRUPT and redirecting the PC to the vector. It tracks the in-interrupt state until RESUME retires; sits beside the stall unit and drives the PC mux and register file write port ahead of them.

## Interface
- NUM_RUPT, 10: number of request sources; index 0 (T6RUPT) is highest priority, 9 (HANDRUPT) lowest
- DRAIN_CYCLES, 2: cycles fetch is held while E and W retire
- RUPT_BASE, 'o4004: vector of source 0
- RUPT_STRIDE, 4: vector spacing in words
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- rupt_req  in  NUM_RUPT  per-source request, sampled every cycle, rising edge sets pending
- inhint_E  in  1  INHINT executing in E: set inhibit
- relint_E  in  1  RELINT executing in E: clear inhibit
- resume_E  in  1  RESUME executing in E
- ovf_A  in  1  accumulator holds overflow (bits 16/15 differ)
- branch_E  in  1  core branch taken this cycle
- stall_D  in  1  core decode stall
- pc_D  in  12  PC of instruction in decode
- rupt_stall  out  1  freeze PC and F/D register
- rupt_flush  out  1  squash D->E register
- zrupt_we  out  1  write ZRUPT
- zrupt_data  out  12  return address
- redirect_en  out  1  force next_pc
- redirect_pc  out  12  vector address
- in_rupt  out  1  interrupt service active
- inhibit  out  1  current INHINT state
- pending  out  NUM_RUPT  latched requests
- active_id  out  4  source being serviced

## Operation
- Pending: bit n sets on a 0->1 transition of rupt_req[n] (previous sample registered). It clears in the VECTOR cycle for active_id only. A set and a clear on the same bit in the same cycle leave the bit set.
- Inhibit: relint_E clears it; inhint_E sets it. If both are asserted, set wins.
- Take condition, evaluated in IDLE: |pending & ~inhibit & ~ovf_A & ~branch_E & ~stall_D.
- States:
  - IDLE -> DRAIN when the take condition holds. In that cycle, capture ret_pc=pc_D and active_id=priority encode of pending.
  - DRAIN: rupt_stall=1. rupt_flush=1 on the first DRAIN cycle only. Counter runs 0..DRAIN_CYCLES-1, then -> SAVE.
  - SAVE: rupt_stall=1, zrupt_we=1, zrupt_data=ret_pc. -> VECTOR.
  - VECTOR: redirect_en=1, redirect_pc=RUPT_BASE+RUPT_STRIDE*active_id. The pending bit clears. -> IN_RUPT.
  - IN_RUPT: in_rupt=1, no new take. resume_E -> IDLE next cycle. The core performs the ZRUPT return itself.
- resume_E outside IN_RUPT is ignored. inhint_E and relint_E update inhibit in any state.
- Priority encoder: lowest set index wins. Vector arithmetic is 12-bit unsigned, with no wrap for legal parameters.
- Reset: state=IDLE, pending=0, inhibit=1, ret_pc=0, active_id=0, counter=0. All strobes are 0, in_rupt=0, redirect_pc=RUPT_BASE. Reset asserted mid-sequence abandons it with no ZRUPT write.

## Timing
- All outputs are registered except redirect_pc and zrupt_data, which are stable state-register decodes.
- Latency from the qualifying pending bit to redirect_en is DRAIN_CYCLES+2 cycles after the IDLE decision cycle.
- Request edge to pending visible: 1 cycle.
- branch_E or stall_D in the decision cycle defers the take by at least one cycle. It is not lost.
- A new request during DRAIN, SAVE, VECTOR or IN_RUPT is latched but not serviced until after IDLE is re-entered.
- IN_RUPT -> IDLE -> DRAIN may occur back-to-back, one IDLE cycle minimum.

## Structure
- In the shared core package: rupt_state_t enum (IDLE, DRAIN, SAVE, VECTOR, IN_RUPT), rupt_id_t (T6, T5, T3, T4, KEY1, KEY2, UP, DOWN, RADAR, HAND), and constants NUM_RUPT, RUPT_BASE, RUPT_STRIDE.
- One sub-module: rupt_priority_encoder (NUM_RUPT-bit vector -> valid, 4-bit index).

## Test plan
- Reset, then pulse rupt_req[2] with inhibit released and pc_D='o4100 -> DRAIN 2 cycles, zrupt_we with data 'o4100, redirect_pc='o4014, pending[2] cleared, in_rupt=1.
- rupt_req[7] and [1] rise in the same cycle -> service 1 (vector 'o4010) first; after resume_E, service 7 (vector 'o4040).
- Inhibit set (reset default) and rupt_req[0] pulses -> pending[0]=1, no entry; relint_E -> entry begins next eligible cycle with vector 'o4004.
- ovf_A=1 or branch_E=1 held 3 cycles with pending[4] -> stays IDLE; condition drops -> entry with vector 'o4024.
- rupt_req[3] rises during IN_RUPT for source 3 -> pending[3] re-set; resume_E -> IDLE, then re-entry to 'o4020.
- reset_n low during SAVE -> next cycle IDLE, zrupt_we=0, pending=0, inhibit=1.
